uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one 8N1 UART byte transmitter between NREQ requesters. Arbitration is round-robin.
//  Sequences the transmitter: load pulse, wait for busy to rise, wait for busy to fall, then
//  an inter-frame gap. Sits between on-board byte sources (switch sampler, status reporters,
//  etc.) and the UART TX serializer that drives UART_TXD.
// PARAMETERS
//  NREQ         4      number of requesters, 2..8
//  GAP_CYCLES   5208   idle cycles after each frame (one bit time at 9600 baud, 50 MHz)
//  BUSY_TIMEOUT 16     max cycles from tx_start until tx_busy must rise
// PORTS
//  CLOCK_50   in   1        system clock; all logic on posedge
//  reset      in   1        synchronous, active-high reset
//  req        in   NREQ     req[i]=1: requester i has a byte pending
//  req_data   in   8*NREQ   byte of requester i on req_data[8*i+7:8*i]
//  ack        out  NREQ     one-cycle pulse: byte of requester i latched
//  tx_start   out  1        one-cycle pulse to transmitter: load tx_data
//  tx_data    out  8        byte to transmit; stable from tx_start until the frame ends
//  tx_busy    in   1        transmitter is shifting a frame
//  grant_id   out  3        index of the current/last granted requester
//  active     out  1        1 in every state except IDLE
//  timeout    out  1        sticky; set when tx_busy fails to rise; cleared by reset only
// BEHAVIOUR
//  Reset: state=IDLE, ack=0, tx_start=0, tx_data=8'h00, grant_id=0, active=0, timeout=0, rr_ptr=0.
//  Arbitration (IDLE, any req=1):
//   - Grant the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   - Same edge: latch the byte into tx_data, set grant_id=i, set rr_ptr=(i+1) mod NREQ,
//     pulse ack[i] for exactly 1 cycle, go to LOAD.
//   - At most one ack bit is high per cycle.
//   - Requesters hold req/req_data stable until they see ack. A req that drops before
//     grant is ignored; no byte is sent for it.
//  FSM:
//   - IDLE: wait for any req.
//   - LOAD: tx_start=1 for 1 cycle, clear tmo_cnt -> WAIT_BUSY.
//   - WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Otherwise tmo_cnt++. tmo_cnt==BUSY_TIMEOUT-1
//     -> set timeout, go to IDLE; the byte is dropped.
//   - WAIT_DONE: tx_busy=0 -> GAP with gap_cnt=0.
//   - GAP: gap_cnt++; gap_cnt==GAP_CYCLES-1 -> IDLE.
//  Latency: ack at cycle 0, tx_start at cycle 1.
//  Throughput: at most one byte per (frame + GAP_CYCLES + 3) cycles.
//  Fairness: with all req held high, grants rotate 0,1,..,NREQ-1,0. No requester waits
//   more than NREQ-1 frames.
//  Request arrivals: new reqs during a frame are only sampled in IDLE. Simultaneous reqs
//   are resolved by rr_ptr.
//  tx_busy glitches outside WAIT_BUSY/WAIT_DONE are ignored.
//  Reset mid-frame: return to IDLE immediately. A latched byte is lost; no ack is re-issued.
//   tx_start is never asserted in the reset cycle.
//  Widths: counters are 32 bits. tmo_cnt/gap_cnt wrap is impossible by construction.
//   grant_id is zero-extended to 3 bits.
// CONFIGURATION
//  UART_SRC_TAG_EN defined:
//   - Each grant sends two frames: first the tag byte {5'b10100, grant_id}, then the data byte.
//   - Added states TAG_LOAD, TAG_WAIT_BUSY, TAG_WAIT_DONE, TAG_GAP are inserted before LOAD.
//     Same rules as the data-byte states, including the GAP after the tag.
//   - ack still pulses at grant time. tx_data shows the tag, then the data byte.
//   - A timeout on the tag aborts the whole grant; the data byte is dropped.
//  UART_SRC_TAG_EN undefined: single data frame per grant, as above.
// TESTING (GAP_CYCLES=8, BUSY_TIMEOUT=4, NREQ=4, transmitter model: busy 2 cycles after start, for 20 cycles)
//  1. req=4'b0100, data2=8'hA5 -> ack=4'b0100 for 1 cycle; tx_start next cycle with tx_data=8'hA5;
//     grant_id=2; active=0 again 8 cycles after tx_busy falls.
//  2. req=4'b1111 held, data i=8'h10+i -> tx_data sequence 10,11,12,13,10; each ack bit
//     pulses once per round.
//  3. rr_ptr=3 after a grant to 2; req=4'b1001 arrive together -> grant 3 first, then 0.
//  4. Model never raises tx_busy -> timeout=1 four cycles after tx_start; FSM returns to IDLE;
//     the next req is served normally; timeout stays 1.
//  5. Reset asserted 5 cycles into WAIT_DONE -> next cycle: active=0, tx_start=0, ack=0,
//     grant_id=0. A following req=4'b0001 is granted normally.
//  6. UART_SRC_TAG_EN, req=4'b0010, data=8'h3C -> tx_data 8'hA1 then 8'h3C;
//     two tx_start pulses separated by frame+gap.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one 8N1 UART byte transmitter between NREQ requesters using
// round-robin arbitration. For each granted byte the scheduler pulses
// tx_start, waits for tx_busy to rise, waits for it to fall, then idles for
// GAP_CYCLES cycles before arbitrating again.
//
// Handshake (requester side): a requester raises req[i] with its byte on
// req_data[8*i+7:8*i] and holds both stable until it sees ack[i]. ack[i] is a
// one-cycle pulse in the cycle the byte is taken. A req dropped before its
// ack is simply never served.
//
// Optional feature: define UART_SRC_TAG_EN to precede every data byte with a
// tag frame {5'b10100, grant_id}. A timeout on the tag drops the whole grant.
//
// Ports:
//   CLOCK_50   in   system clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   req        in   NREQ pending-byte flags
//   req_data   in   8*NREQ bytes, requester i on [8*i+7:8*i]
//   ack        out  one-cycle pulse: byte of requester i latched
//   tx_start   out  one-cycle load pulse to the transmitter
//   tx_data    out  byte being transmitted, stable for the whole frame
//   tx_busy    in   transmitter is shifting a frame
//   grant_id   out  index of the current/last granted requester
//   active     out  1 in every state except IDLE
//   timeout    out  sticky: tx_busy failed to rise in time
//   state_dbg  out  current FSM state encoding
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NREQ         = 4,
    parameter int GAP_CYCLES   = 5208,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_busy,
    output logic [2:0]          grant_id,
    output logic                active,
    output logic                timeout,
    output logic [3:0]          state_dbg
);

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        LOAD          = 4'd1,
        WAIT_BUSY     = 4'd2,
        WAIT_DONE     = 4'd3,
        GAP           = 4'd4,
        TAG_LOAD      = 4'd5,
        TAG_WAIT_BUSY = 4'd6,
        TAG_WAIT_DONE = 4'd7,
        TAG_GAP       = 4'd8
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  data_byte_q, data_byte_d;   // data byte parked while the tag is sent
    logic [2:0]  grant_id_q, grant_id_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic        timeout_q, timeout_d;

    // Round-robin search starting at rr_ptr
    logic        found;
    int          win_j;
    logic [7:0]  win_data;

    always_comb begin
        found    = 1'b0;
        win_j    = 0;
        win_data = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(rr_ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                win_j    = j;
                win_data = req_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        data_byte_d = data_byte_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        tmo_cnt_d   = tmo_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        timeout_d   = timeout_q;
        ack         = '0;
        tx_start    = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    ack[win_j]  = 1'b1;
                    grant_id_d  = 3'(win_j);
                    rr_ptr_d    = (win_j == NREQ - 1) ? 3'd0 : 3'(win_j + 1);
                    data_byte_d = win_data;
`ifdef UART_SRC_TAG_EN
                    tx_data_d   = {5'b10100, 3'(win_j)};
                    state_d     = TAG_LOAD;
`else
                    tx_data_d   = win_data;
                    state_d     = LOAD;
`endif
                end
            end

            LOAD, TAG_LOAD: begin
                tx_start  = 1'b1;
                tmo_cnt_d = 32'd0;
                state_d   = (state_q == LOAD) ? WAIT_BUSY : TAG_WAIT_BUSY;
            end

            WAIT_BUSY, TAG_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = (state_q == WAIT_BUSY) ? WAIT_DONE : TAG_WAIT_DONE;
                end else if (tmo_cnt_q == 32'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never picked the byte up: drop the grant.
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end

            WAIT_DONE, TAG_WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_cnt_d = 32'd0;
                    state_d   = (state_q == WAIT_DONE) ? GAP : TAG_GAP;
                end
            end

            GAP, TAG_GAP: begin
                if (gap_cnt_q == 32'(GAP_CYCLES - 1)) begin
                    if (state_q == TAG_GAP) begin
                        tx_data_d = data_byte_q;
                        state_d   = LOAD;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end

            default: state_d = IDLE;
        endcase

        // Pulses must never leak out while reset is being applied.
        if (reset) begin
            ack      = '0;
            tx_start = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            tx_data_q   <= 8'h00;
            data_byte_q <= 8'h00;
            grant_id_q  <= 3'd0;
            rr_ptr_q    <= 3'd0;
            tmo_cnt_q   <= 32'd0;
            gap_cnt_q   <= 32'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            data_byte_q <= data_byte_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign grant_id  = grant_id_q;
    assign active    = (state_q != IDLE);
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler with NREQ=4, GAP_CYCLES=8,
// BUSY_TIMEOUT=4. The transmitter is modelled inline: tx_busy rises two
// cycles after tx_start and stays high for 20 cycles. Inputs are driven 1 ns
// after the rising edge, outputs are sampled a few ns later.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    logic        CLOCK_50;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [2:0]  grant_id;
    logic        active;
    logic        timeout;
    logic [3:0]  state_dbg;

    int n_pass;
    int n_total;

    uart_tx_scheduler #(
        .NREQ         (4),
        .GAP_CYCLES   (8),
        .BUSY_TIMEOUT (4)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    // Clock / watchdog
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, pass=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    task automatic next();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Entered in the LOAD (or TAG_LOAD) cycle; leaves in the cycle after the
    // gap, having checked active there against exp_active_end.
    task automatic do_frame(input logic [7:0] exp_byte, input logic [2:0] exp_gid,
                            input logic exp_active_end);
        int bad_start;
        int bad_data;
        int bad_ack;
        int bad_active;
        bad_start  = 0;
        bad_data   = 0;
        bad_ack    = 0;
        bad_active = 0;
        settle();
        n_total++;
        if (tx_start !== 1'b1) $display("FAIL frame_tx_start: got %b want 1", tx_start);
        else n_pass++;
        n_total++;
        if (tx_data !== exp_byte) $display("FAIL frame_tx_data: got %h want %h", tx_data, exp_byte);
        else n_pass++;
        n_total++;
        if (grant_id !== exp_gid) $display("FAIL frame_grant_id: got %0d want %0d", grant_id, exp_gid);
        else n_pass++;
        next();
        settle();
        if (tx_start !== 1'b0) bad_start++;
        next();
        tx_busy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (tx_start !== 1'b0)   bad_start++;
            if (tx_data !== exp_byte) bad_data++;
            if (ack !== 4'b0000)     bad_ack++;
            if (active !== 1'b1)     bad_active++;
            next();
        end
        tx_busy = 1'b0;
        // WAIT_DONE sees busy low, then exactly 8 gap cycles
        for (int g = 0; g < 9; g++) begin
            settle();
            if (tx_start !== 1'b0)   bad_start++;
            if (tx_data !== exp_byte) bad_data++;
            if (ack !== 4'b0000)     bad_ack++;
            if (active !== 1'b1)     bad_active++;
            next();
        end
        settle();
        n_total++;
        if (active !== exp_active_end) $display("FAIL frame_end_active: got %b want %b", active, exp_active_end);
        else n_pass++;
        n_total++;
        if (bad_start != 0) $display("FAIL frame_extra_start: got %0d stray pulses want 0", bad_start);
        else n_pass++;
        n_total++;
        if (bad_data != 0) $display("FAIL frame_data_stable: got %0d unstable cycles want 0", bad_data);
        else n_pass++;
        n_total++;
        if (bad_ack != 0 || bad_active != 0)
            $display("FAIL frame_ack_active: got ack_err=%0d active_err=%0d want 0/0", bad_ack, bad_active);
        else n_pass++;
    endtask

    task automatic serve(input logic [7:0] data, input logic [2:0] gid);
`ifdef UART_SRC_TAG_EN
        do_frame({5'b10100, gid}, gid, 1'b1);
`endif
        do_frame(data, gid, 1'b0);
    endtask

    task automatic pulse_reset();
        next();
        reset = 1'b1;
        next();
        next();
        reset   = 1'b0;
        tx_busy = 1'b0;
        req     = 4'b0000;
        settle();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req      = 4'b1111;
        req_data = 32'h0;
        tx_busy  = 1'b0;
        next();
        next();
        settle();
        n_total++;
        if (ack !== 4'b0000 || tx_start !== 1'b0)
            $display("FAIL reset_pulses: got ack=%b tx_start=%b want 0000/0", ack, tx_start);
        else n_pass++;
        next();
        reset = 1'b0;
        req   = 4'b0000;
        settle();
        n_total++;
        if (active !== 1'b0 || state_dbg !== 4'd0)
            $display("FAIL reset_state: got active=%b state=%0d want 0/0", active, state_dbg);
        else n_pass++;
        n_total++;
        if (tx_data !== 8'h00 || grant_id !== 3'd0 || timeout !== 1'b0)
            $display("FAIL reset_regs: got data=%h gid=%0d tmo=%b want 00/0/0", tx_data, grant_id, timeout);
        else n_pass++;
    endtask

    task automatic test_single();
        req      = 4'b0100;
        req_data = 32'h00A5_0000;
        #1;
        n_total++;
        if (ack !== 4'b0100) $display("FAIL single_ack: got %b want 0100", ack);
        else n_pass++;
        next();
        req = 4'b0000;
        serve(8'hA5, 3'd2);
    endtask

    task automatic test_rr_ptr();
        // previous grant went to 2, so 3 is searched first
        req      = 4'b1001;
        req_data = 32'h3300_0030;
        #1;
        n_total++;
        if (ack !== 4'b1000) $display("FAIL rr_first_ack: got %b want 1000", ack);
        else n_pass++;
        next();
        req = 4'b0001;
        serve(8'h33, 3'd3);
        #1;
        n_total++;
        if (ack !== 4'b0001) $display("FAIL rr_second_ack: got %b want 0001", ack);
        else n_pass++;
        next();
        req = 4'b0000;
        serve(8'h30, 3'd0);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack;
        int         gi;
        req      = 4'b1111;
        req_data = 32'h1312_1110;
        for (int r = 0; r < 5; r++) begin
            gi      = r % 4;
            exp_ack = 4'b0001 << gi;
            #1;
            n_total++;
            if (ack !== exp_ack) $display("FAIL rr_round_ack%0d: got %b want %b", r, ack, exp_ack);
            else n_pass++;
            next();
            serve(8'h10 + 8'(gi), 3'(gi));
        end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        logic [7:0] exp_load;
        int         bad;
`ifdef UART_SRC_TAG_EN
        exp_load = 8'hA1;
`else
        exp_load = 8'h44;
`endif
        bad      = 0;
        req      = 4'b0010;
        req_data = 32'h0000_4400;
        #1;
        n_total++;
        if (ack !== 4'b0010) $display("FAIL tmo_ack: got %b want 0010", ack);
        else n_pass++;
        next();
        req = 4'b0000;
        settle();
        n_total++;
        if (tx_start !== 1'b1 || tx_data !== exp_load)
            $display("FAIL tmo_load: got start=%b data=%h want 1/%h", tx_start, tx_data, exp_load);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            next();
            settle();
            if (timeout !== 1'b0 || active !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL tmo_early: got %0d bad cycles want 0", bad);
        else n_pass++;
        next();
        settle();
        n_total++;
        if (timeout !== 1'b1 || active !== 1'b0 || state_dbg !== 4'd0)
            $display("FAIL tmo_set: got tmo=%b active=%b state=%0d want 1/0/0", timeout, active, state_dbg);
        else n_pass++;
        req      = 4'b0001;
        req_data = 32'h0000_0055;
        #1;
        n_total++;
        if (ack !== 4'b0001) $display("FAIL tmo_next_ack: got %b want 0001", ack);
        else n_pass++;
        next();
        req = 4'b0000;
        serve(8'h55, 3'd0);
        n_total++;
        if (timeout !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", timeout);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        req      = 4'b0100;
        req_data = 32'h0066_0000;
        #1;
        next();
        req = 4'b0000;
        next();
        next();
        tx_busy = 1'b1;
        // WAIT_DONE starts next cycle; assert reset in its 5th cycle
        for (int k = 0; k < 5; k++) next();
        reset = 1'b1;
        next();
        reset   = 1'b0;
        tx_busy = 1'b0;
        settle();
        n_total++;
        if (active !== 1'b0 || tx_start !== 1'b0 || ack !== 4'b0000 || grant_id !== 3'd0)
            $display("FAIL midreset_state: got active=%b start=%b ack=%b gid=%0d want 0/0/0000/0",
                     active, tx_start, ack, grant_id);
        else n_pass++;
        // busy glitch in IDLE must be ignored
        next();
        tx_busy = 1'b1;
        next();
        tx_busy = 1'b0;
        settle();
        n_total++;
        if (active !== 1'b0 || tx_start !== 1'b0)
            $display("FAIL busy_glitch: got active=%b start=%b want 0/0", active, tx_start);
        else n_pass++;
        req      = 4'b0001;
        req_data = 32'h0000_0077;
        #1;
        n_total++;
        if (ack !== 4'b0001) $display("FAIL midreset_next_ack: got %b want 0001", ack);
        else n_pass++;
        next();
        req = 4'b0000;
        serve(8'h77, 3'd0);
    endtask

`ifdef UART_SRC_TAG_EN
    task automatic test_tag();
        req      = 4'b0010;
        req_data = 32'h0000_3C00;
        #1;
        n_total++;
        if (ack !== 4'b0010) $display("FAIL tag_ack: got %b want 0010", ack);
        else n_pass++;
        next();
        req = 4'b0000;
        do_frame(8'hA1, 3'd1, 1'b1);
        do_frame(8'h3C, 3'd1, 1'b0);
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        req     = 4'b0000;
        req_data = 32'h0;
        tx_busy = 1'b0;
        test_reset();
        test_single();
        test_rr_ptr();
        pulse_reset();
        test_round_robin();
        test_timeout();
        test_reset_mid_frame();
`ifdef UART_SRC_TAG_EN
        test_tag();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
